axi4_lite_master: RTL and testbench
===================================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the AXI address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the AXI data width; the strobe width is DATA_W/8.
REQ-003 ACLK  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 ARESETN  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  SHALL form the command handshake.
REQ-006 cmd_write  input  1  SHALL select the operation: 1 = write, 0 = read.
REQ-007 cmd_addr / cmd_wdata / cmd_wstrb  input  ADDR_W / DATA_W / DATA_W/8  SHALL carry the command payload.
REQ-008 rsp_valid / rsp_ready  output / input  1 / 1  SHALL form the response handshake.
REQ-009 rsp_rdata / rsp_resp / rsp_write  output  DATA_W / 2 / 1  SHALL carry the response payload: read data, the BRESP or RRESP value, and the operation type.
REQ-010 AWADDR, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY SHALL be the standard AXI4-Lite master-side ports.
REQ-011 wr_count / rd_count  output  16 / 16  SHALL count completed writes and completed reads.

Function
REQ-012 The FSM SHALL have the states IDLE, WR (AW/W phase), WR_B, RD_AR, RD_R and RSP.
REQ-013 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the cycle where cmd_valid and cmd_ready are both 1.
REQ-014 On an accepted write, the block SHALL:
- register the address, data and strobe;
- assert AWVALID and WVALID together on the next cycle;
- move to WR.
REQ-015 In WR, each of AWVALID and WVALID SHALL drop independently on the cycle after its own READY is sampled 1, and its payload SHALL stay stable while VALID is 1.
REQ-016 The slave SHALL be allowed to assert AWREADY and WREADY in any order or in the same cycle; WR SHALL exit to WR_B only when both handshakes are done.
REQ-017 In WR_B, BREADY SHALL be 1.
REQ-018 On BVALID && BREADY, the block SHALL:
- capture BRESP into rsp_resp;
- set rsp_write to 1 and rsp_rdata to 0;
- increment wr_count;
- move to RSP.
REQ-019 On an accepted read, the block SHALL assert ARVALID with the registered address and move to RD_AR; ARVALID SHALL drop after ARREADY is sampled 1, then the FSM moves to RD_R.
REQ-020 In RD_R, RREADY SHALL be 1.
REQ-021 On RVALID && RREADY, the block SHALL:
- capture RDATA and RRESP;
- set rsp_write to 0;
- increment rd_count;
- move to RSP.
REQ-022 If ARREADY and RVALID are sampled in the same cycle, or RVALID arrives while in RD_AR, the read data SHALL still be captured correctly with no lost beat.
REQ-023 In RSP, rsp_valid SHALL be 1 and the payload SHALL be held stable until rsp_ready is 1; the FSM then returns to IDLE.
REQ-024 Only one transaction SHALL be outstanding at a time; no VALID is ever deasserted before its handshake.
REQ-025 wr_count and rd_count SHALL wrap from 0xFFFF to 0x0000.
REQ-026 All outputs SHALL be registered.
REQ-027 Minimum latency from command accept to rsp_valid SHALL be 3 cycles, reached when the slave is ready with zero wait.

Reset
REQ-028 On ARESETN low, the FSM SHALL go to IDLE and all VALID/READY outputs, counters, response fields and AXI payload outputs SHALL be 0; cmd_ready becomes 1 on the first clock after release.
REQ-029 A reset mid-transaction SHALL abandon the transaction with no response generated.

Structure
REQ-030 The state enum and the AXI response codes (OKAY=2'b00, SLVERR=2'b10) SHALL live in the shared package axi4_lite_pkg.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Write 0x10, data 0xDEADBEEF, strobe 0xF, to the existing axi4_lite_1 slave -> rsp_valid with rsp_write=1, rsp_resp=00, and wr_count=1.
REQ-033 Then read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rd_count=1.
REQ-034 Stub slave with AWREADY 3 cycles before WREADY, then the reverse -> each VALID drops only after its own handshake, and exactly one response.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp payload stable, cmd_ready stays 0, and a new cmd_valid is not accepted.
REQ-036 Stub slave returns BRESP=10 for address 0x90 -> rsp_resp=10.
REQ-037 ARESETN pulsed low while in WR_B -> all outputs 0 and no rsp_valid; the next write completes normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: FSM state encoding and response codes.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI transaction
// and returns the result on a registered response handshake.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_write,

    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY,

    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    state_t state;

    // A channel is finished once its VALID has dropped or its handshake happens this edge.
    logic aw_done, w_done, ar_done, r_done;
    assign aw_done = !AWVALID || AWREADY;
    assign w_done  = !WVALID  || WREADY;
    assign ar_done = !ARVALID || ARREADY;
    assign r_done  = !RREADY  || RVALID;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            rsp_write <= 1'b0;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            AWADDR  <= cmd_addr;
                            WDATA   <= cmd_wdata;
                            WSTRB   <= cmd_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= WR;
                        end else begin
                            // RREADY goes up with ARVALID so early read data is never dropped.
                            ARADDR  <= cmd_addr;
                            ARVALID <= 1'b1;
                            RREADY  <= 1'b1;
                            state   <= RD_AR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                WR: begin
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                    if (aw_done && w_done) begin
                        BREADY <= 1'b1;
                        state  <= WR_B;
                    end
                end

                WR_B: begin
                    if (BVALID && BREADY) begin
                        BREADY    <= 1'b0;
                        rsp_resp  <= BRESP;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        wr_count  <= wr_count + 16'd1;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end

                RD_AR: begin
                    if (ARREADY) ARVALID <= 1'b0;
                    if (RVALID && RREADY) begin
                        RREADY    <= 1'b0;
                        rsp_rdata <= RDATA;
                        rsp_resp  <= RRESP;
                        rsp_write <= 1'b0;
                        rd_count  <= rd_count + 16'd1;
                    end
                    if (ar_done && r_done) begin
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else if (ar_done) begin
                        state <= RD_R;
                    end
                end

                RD_R: begin
                    if (RVALID && RREADY) begin
                        RREADY    <= 1'b0;
                        rsp_rdata <= RDATA;
                        rsp_resp  <= RRESP;
                        rsp_write <= 1'b0;
                        rd_count  <= rd_count + 16'd1;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Randomized scoreboard bench for axi4_lite_master with a behavioural memory slave
// and an independent reference model of the expected responses.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;

    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [STRB_W-1:0] WSTRB;
    logic [1:0]        BRESP, RRESP;
    logic [15:0]       wr_count, rd_count;

    always #5 ACLK = ~ACLK;

    axi4_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [15:0] wc;
        logic [15:0] rc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_issued = 0;
    int          n_rsp = 0;
    logic [31:0] model_mem [256];
    logic [15:0] model_wr = '0;
    logic [15:0] model_rd = '0;

    logic [31:0] slv_mem [256];
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit          early_r, hold_rsp;
    int          aw_only, w_only;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        checkOutput({tag, "_valids"}, 64'({AWVALID, WVALID, ARVALID, rsp_valid}), 64'd0);
        checkOutput({tag, "_readys"}, 64'({BREADY, RREADY}), 64'd0);
        checkOutput({tag, "_counts"}, 64'({wr_count, rd_count}), 64'd0);
        checkOutput({tag, "_rsp_fields"}, 64'({rsp_rdata, rsp_resp, rsp_write}), 64'd0);
        checkOutput({tag, "_axi_payload"}, {AWADDR, ARADDR, WSTRB, WDATA}, 64'd0);
    endtask

    // Reference model: the result follows from memory semantics, not from the master's FSM.
    task automatic issueCmd(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit expect_rsp);
        exp_t e;
        logic [31:0] mask;
        if (expect_rsp) begin
            e.wr = wr;
            if (wr) begin
                e.rdata = '0;
                if (a == 8'h90) begin
                    e.resp = RESP_SLVERR;
                end else begin
                    e.resp = RESP_OKAY;
                    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                    model_mem[a] = (model_mem[a] & ~mask) | (d & mask);
                end
                model_wr = model_wr + 16'd1;
            end else begin
                e.rdata = model_mem[a];
                e.resp = RESP_OKAY;
                model_rd = model_rd + 16'd1;
            end
            e.wc = model_wr;
            e.rc = model_rd;
            exp_q.push_back(e);
            n_issued++;
        end
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    task automatic waitAccept();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge ACLK);
            if (cmd_ready) begin
                ok = 1'b1;
                @(posedge ACLK);
                #1;
            end
        end
        cmd_valid = 1'b0;
        checkOutput("cmd_accepted", 64'(ok), 64'd1);
    endtask

    task automatic applyStimulus(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        issueCmd(wr, a, d, s, 1'b1);
        waitAccept();
    endtask

    task automatic waitIdle();
        bit idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge ACLK);
            idle = (exp_q.size() == 0) && cmd_ready;
        end
        checkOutput("idle_reached", 64'(idle), 64'd1);
        checkOutput("rsp_count", 64'(n_rsp), 64'(n_issued));
    endtask

    // Memory slave with per-channel wait states; handshakes are sampled mid-cycle.
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, got_ar;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [7:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;

    initial begin : slave_model
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        forever begin
            @(negedge ACLK);
            aw_hs = ARESETN && AWVALID && AWREADY;
            w_hs  = ARESETN && WVALID && WREADY;
            b_hs  = ARESETN && BVALID && BREADY;
            ar_hs = ARESETN && ARVALID && ARREADY;
            r_hs  = ARESETN && RVALID && RREADY;
            if (aw_hs) s_awaddr = AWADDR;
            if (w_hs) begin s_wdata = WDATA; s_wstrb = WSTRB; end
            if (ar_hs) s_araddr = ARADDR;
            @(posedge ACLK);
            #1;
            if (!ARESETN) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
                ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
                got_aw = 0; got_w = 0; got_ar = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (aw_hs) begin AWREADY = 0; got_aw = 1; aw_cnt = 0; end
                else if (AWVALID && !got_aw && !AWREADY) begin
                    if (aw_cnt >= aw_dly) AWREADY = 1; else aw_cnt++;
                end
                if (w_hs) begin WREADY = 0; got_w = 1; w_cnt = 0; end
                else if (WVALID && !got_w && !WREADY) begin
                    if (w_cnt >= w_dly) WREADY = 1; else w_cnt++;
                end
                if (b_hs) begin BVALID = 0; got_aw = 0; got_w = 0; b_cnt = 0; end
                else if (got_aw && got_w && !BVALID) begin
                    if (b_cnt >= b_dly) begin
                        BVALID = 1;
                        if (s_awaddr == 8'h90) BRESP = RESP_SLVERR;
                        else begin
                            BRESP = RESP_OKAY;
                            for (int i = 0; i < 4; i++)
                                if (s_wstrb[i]) slv_mem[s_awaddr][8*i +: 8] = s_wdata[8*i +: 8];
                        end
                    end else b_cnt++;
                end
                if (ar_hs) begin ARREADY = 0; got_ar = !r_hs; ar_cnt = 0; end
                else if (ARVALID && !got_ar && !ARREADY) begin
                    if (ar_cnt >= ar_dly) begin
                        ARREADY = 1;
                        if (early_r) begin RVALID = 1; RDATA = slv_mem[ARADDR]; RRESP = RESP_OKAY; end
                    end else ar_cnt++;
                end
                if (r_hs) begin RVALID = 0; got_ar = 0; r_cnt = 0; end
                else if (got_ar && !RVALID) begin
                    if (r_cnt >= r_dly) begin RVALID = 1; RDATA = slv_mem[s_araddr]; RRESP = RESP_OKAY; end
                    else r_cnt++;
                end
            end
        end
    end

    initial begin : rsp_ready_driver
        rsp_ready = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: pops one expectation per completed response handshake.
    exp_t        m_e;
    bit          m_held = 1'b0;
    logic [31:0] m_rdata;
    logic [1:0]  m_resp;
    logic        m_write;

    initial begin : monitor
        forever begin
            @(negedge ACLK);
            if (!ARESETN) m_held = 1'b0;
            else if (rsp_valid) begin
                if (m_held) checkOutput("rsp_stable", {rsp_rdata, rsp_resp, rsp_write}, {m_rdata, m_resp, m_write});
                if (rsp_ready) begin
                    m_held = 1'b0;
                    n_rsp++;
                    checkOutput("rsp_has_expectation", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        m_e = exp_q.pop_front();
                        checkOutput("rsp_write", 64'(rsp_write), 64'(m_e.wr));
                        checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(m_e.rdata));
                        checkOutput("rsp_resp", 64'(rsp_resp), 64'(m_e.resp));
                        checkOutput("wr_count", 64'(wr_count), 64'(m_e.wc));
                        checkOutput("rd_count", 64'(rd_count), 64'(m_e.rc));
                    end
                end else begin
                    m_held = 1'b1;
                    m_rdata = rsp_rdata;
                    m_resp = rsp_resp;
                    m_write = rsp_write;
                end
            end else begin
                if (m_held) checkOutput("rsp_valid_held", 64'(rsp_valid), 64'd1);
                m_held = 1'b0;
            end
        end
    end

    // Protocol watcher: each VALID holds with stable payload until its handshake, then drops.
    bit          p_ok = 1'b0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [7:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;

    initial begin : protocol_watch
        forever begin
            @(negedge ACLK);
            if (!ARESETN) p_ok = 1'b0;
            else begin
                if (p_ok) begin
                    if (p_awv && p_awr) checkOutput("awvalid_drop", 64'(AWVALID), 64'd0);
                    else if (p_awv) checkOutput("awvalid_hold", 64'({AWVALID, AWADDR}), 64'({1'b1, p_awaddr}));
                    if (p_wv && p_wr) checkOutput("wvalid_drop", 64'(WVALID), 64'd0);
                    else if (p_wv) checkOutput("wvalid_hold", 64'({WVALID, WDATA}), 64'({1'b1, p_wdata}));
                    if (p_arv && p_arr) checkOutput("arvalid_drop", 64'(ARVALID), 64'd0);
                    else if (p_arv) checkOutput("arvalid_hold", 64'({ARVALID, ARADDR}), 64'({1'b1, p_araddr}));
                end
                if (AWVALID && !WVALID) aw_only++;
                if (WVALID && !AWVALID) w_only++;
                p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
                p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA;
                p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
                p_ok = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit          seen;
        logic [31:0] c_rdata;
        logic [7:0]  a;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = '0;
            model_mem[i] = '0;
        end
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        early_r = 0; hold_rsp = 0;

        repeat (2) @(negedge ACLK);
        checkResetState("por");
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        @(negedge ACLK);
        checkOutput("cmd_ready_before_clock", 64'(cmd_ready), 64'd0);
        @(negedge ACLK);
        checkOutput("cmd_ready_first_clock", 64'(cmd_ready), 64'd1);

        $display("[TB] basic write then read of 0x10");
        applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        waitIdle();
        applyStimulus(1'b0, 8'h10, 32'h0, 4'h0);
        waitIdle();

        $display("[TB] AWREADY ahead of WREADY, then the reverse");
        w_dly = 3; aw_only = 0; w_only = 0;
        applyStimulus(1'b1, 8'h14, 32'hA5A5_0F0F, 4'b0101);
        waitIdle();
        checkOutput("w_only_cycles", 64'(w_only), 64'd3);
        checkOutput("aw_only_cycles", 64'(aw_only), 64'd0);
        aw_dly = 3; w_dly = 0; aw_only = 0; w_only = 0;
        applyStimulus(1'b1, 8'h18, 32'h1357_9BDF, 4'b1010);
        waitIdle();
        checkOutput("aw_only_cycles_rev", 64'(aw_only), 64'd3);
        checkOutput("w_only_cycles_rev", 64'(w_only), 64'd0);
        aw_dly = 0;
        applyStimulus(1'b0, 8'h14, 32'h0, 4'h0);
        waitIdle();

        $display("[TB] slave error on 0x90");
        applyStimulus(1'b1, 8'h90, 32'h1111_2222, 4'hF);
        waitIdle();

        $display("[TB] response backpressure with a pending command");
        hold_rsp = 1'b1;
        applyStimulus(1'b1, 8'h1C, 32'hFEED_0001, 4'hF);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ACLK);
            seen = rsp_valid;
        end
        checkOutput("rsp_valid_under_hold", 64'(seen), 64'd1);
        c_rdata = rsp_rdata;
        issueCmd(1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
        repeat (5) begin
            @(negedge ACLK);
            checkOutput("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            checkOutput("hold_rsp_payload", 64'({rsp_valid, rsp_write, rsp_rdata}), 64'({2'b11, c_rdata}));
        end
        hold_rsp = 1'b0;
        waitAccept();
        waitIdle();

        $display("[TB] read data together with ARREADY");
        early_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ar_dly = k;
            applyStimulus(1'b0, 8'h18, 32'h0, 4'h0);
            waitIdle();
        end
        early_r = 1'b0; ar_dly = 0;

        $display("[TB] reset while waiting for the write response");
        b_dly = 12;
        issueCmd(1'b1, 8'h24, 32'h1234_5678, 4'hF, 1'b0);
        waitAccept();
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge ACLK);
            seen = BREADY;
        end
        checkOutput("reached_wr_b", 64'(seen), 64'd1);
        #1 ARESETN = 1'b0;
        model_wr = '0;
        model_rd = '0;
        repeat (3) begin
            @(negedge ACLK);
            checkResetState("mid_reset");
        end
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        b_dly = 0;
        applyStimulus(1'b1, 8'h24, 32'hCAFE_F00D, 4'hF);
        waitIdle();
        applyStimulus(1'b0, 8'h24, 32'h0, 4'h0);
        waitIdle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 2);
            ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            early_r = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 7) == 0) ? 8'h90 : 8'(8'h10 + 4 * $urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 1) == 1), a, $urandom, 4'($urandom_range(1, 15)));
        end
        waitIdle();

        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
